cond_unit: RTL and testbench

- Conditional-execution stage of the multicycle ARM core; sits directly downstream of the instruction decoder.
- Consumes the decoder's FlagW, PCS, NextPC, RegW and MemW, plus the instruction condition field and the ALU flags.
- Holds the architectural NZCV register and evaluates the 4-bit condition code.
- Produces the condition-gated write enables PCWrite, RegWrite and MemWrite that drive the datapath.

---
 rtl/cond_unit.sv | 135 +++++++++++++
 tb/tb_cond_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cond_unit.sv
// cond_unit: conditional-execution stage of the multicycle ARM core.
// Holds the architectural NZCV flags and evaluates the instruction's 4-bit
// condition field once per instruction, at the end of the decode cycle. The
// registered result (CondEx) gates the decoder's PC, register-file and memory
// write requests, and it also gates the flag writes.
// Optional feature: define COND_UNIT_PERF_CNT_EN to build the executed and
// squashed instruction counters (ExecCnt / SkipCnt). Without the macro, both
// outputs are tied to zero and no counter flops are built.
module cond_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             NextPC,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [3:0]       Flags,
    output logic             CondEx,
    output logic [CNT_W-1:0] ExecCnt,
    output logic [CNT_W-1:0] SkipCnt
);

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    logic       n_flag, z_flag, c_flag, v_flag;
    logic       cond_comb;
    logic       decode_pending;
    logic [1:0] flag_we;

    assign {n_flag, z_flag, c_flag, v_flag} = Flags;

    // The fetch cycle must never write flags. CondEx can still hold the
    // previous instruction's result while IRWrite is high, so the write is
    // masked explicitly.
    assign flag_we = FlagW & {2{CondEx & ~IRWrite}};

    // Condition evaluation uses only the registered flags, never ALUFlags.
    always_comb begin
        // NOTE: assigning a default first means every path drives cond_comb,
        // so no latch can be inferred even if a case arm is later dropped.
        cond_comb = 1'b1;
        case (cond_e'(Cond))
            COND_EQ: cond_comb = z_flag;
            COND_NE: cond_comb = ~z_flag;
            COND_CS: cond_comb = c_flag;
            COND_CC: cond_comb = ~c_flag;
            COND_MI: cond_comb = n_flag;
            COND_PL: cond_comb = ~n_flag;
            COND_VS: cond_comb = v_flag;
            COND_VC: cond_comb = ~v_flag;
            COND_HI: cond_comb = c_flag & ~z_flag;
            COND_LS: cond_comb = ~c_flag | z_flag;
            COND_GE: cond_comb = (n_flag == v_flag);
            COND_LT: cond_comb = (n_flag != v_flag);
            COND_GT: cond_comb = ~z_flag & (n_flag == v_flag);
            COND_LE: cond_comb = z_flag | (n_flag != v_flag);
            default: cond_comb = 1'b1;   // AL, and 1111 treated as AL
        endcase
    end

    // Decode-pending marks the single cycle that follows the instruction fetch.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // flop samples the values from before the edge, whatever order the
        // blocks run in.
        if (!reset) decode_pending <= 1'b0;
        else        decode_pending <= IRWrite;
    end

    // CondEx is cleared at fetch, loaded at the end of decode, and then held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              CondEx <= 1'b0;
        else if (IRWrite)        CondEx <= 1'b0;
        else if (decode_pending) CondEx <= cond_comb;
    end

    // The N,Z half and the C,V half of the flags update independently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Flags <= 4'b0000;
        end else begin
            if (flag_we[1]) Flags[3:2] <= ALUFlags[3:2];
            if (flag_we[0]) Flags[1:0] <= ALUFlags[1:0];
        end
    end

    // The write enables are gated by the registered condition. A fetch (NextPC)
    // always updates the PC.
    assign PCWrite  = (PCS & CondEx) | NextPC;
    assign RegWrite = RegW & CondEx;
    assign MemWrite = MemW & CondEx;

`ifdef COND_UNIT_PERF_CNT_EN
    // Each evaluated instruction is counted once, at the end of its decode
    // cycle. Both counters wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ExecCnt <= '0;
            SkipCnt <= '0;
        end else if (decode_pending) begin
            if (cond_comb) ExecCnt <= ExecCnt + 1'b1;
            else           SkipCnt <= SkipCnt + 1'b1;
        end
    end
`else
    assign ExecCnt = '0;
    assign SkipCnt = '0;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Testbench for cond_unit. It uses directed instruction sequences (fetch,
// decode, execute) with expected values computed by hand. Two instances share
// the same inputs: one uses the default counter width and one uses CNT_W=4,
// so that counter wrap can be observed.
module tb_cond_unit;

    logic        clk;
    logic        reset;
    logic [3:0]  Cond;
    logic [3:0]  ALUFlags;
    logic [1:0]  FlagW;
    logic        PCS, NextPC, RegW, MemW, IRWrite;

    logic        PCWrite, RegWrite, MemWrite, CondEx;
    logic [3:0]  Flags;
    logic [31:0] ExecCnt, SkipCnt;

    logic        small_pc_write, small_reg_write, small_mem_write, small_cond_ex;
    logic [3:0]  small_flags;
    logic [3:0]  small_exec_cnt, small_skip_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [3:0]  exp_flags;
    int          exp_exec;
    int          exp_skip;

    cond_unit dut (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .Flags(Flags), .CondEx(CondEx), .ExecCnt(ExecCnt), .SkipCnt(SkipCnt)
    );

    cond_unit #(.CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .IRWrite(IRWrite),
        .PCWrite(small_pc_write), .RegWrite(small_reg_write), .MemWrite(small_mem_write),
        .Flags(small_flags), .CondEx(small_cond_ex),
        .ExecCnt(small_exec_cnt), .SkipCnt(small_skip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference condition table, written out directly from the ARM encoding.
    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    task automatic check_counters(input string tag);
        logic [31:0] want_exec, want_skip;
`ifdef COND_UNIT_PERF_CNT_EN
        want_exec = exp_exec;
        want_skip = exp_skip;
`else
        want_exec = 0;
        want_skip = 0;
`endif
        check({tag, "_exec"}, ExecCnt, want_exec);
        check({tag, "_skip"}, SkipCnt, want_skip);
        check({tag, "_exec4"}, {28'd0, small_exec_cnt}, {28'd0, want_exec[3:0]});
        check({tag, "_skip4"}, {28'd0, small_skip_cnt}, {28'd0, want_skip[3:0]});
    endtask

    // The task runs one three-cycle instruction: fetch, decode, and one execute
    // cycle. It is entered and left 1 time unit after a rising edge.
    task automatic run_instr(input logic [3:0] cond, input logic regw, input logic memw,
                             input logic pcs, input logic [1:0] flagw,
                             input logic [3:0] alu, input logic [1:0] fetch_flagw);
        logic ex;
        // fetch
        Cond = cond; IRWrite = 1'b1; NextPC = 1'b1; FlagW = fetch_flagw; ALUFlags = alu;
        RegW = 1'b0; MemW = 1'b0; PCS = 1'b0;
        @(negedge clk);
        check("fetch_pcwrite", PCWrite, 1'b1);
        @(posedge clk); #1;
        // decode
        IRWrite = 1'b0; NextPC = 1'b0; FlagW = 2'b00;
        @(negedge clk);
        check("decode_condex", CondEx, 1'b0);
        ex = cond_model(cond, exp_flags);
        @(posedge clk); #1;
        if (ex) exp_exec++; else exp_skip++;
        // execute
        RegW = regw; MemW = memw; PCS = pcs; FlagW = flagw; ALUFlags = alu;
        @(negedge clk);
        check($sformatf("condex_c%0h_f%0h", cond, exp_flags), CondEx, ex);
        check("regwrite", RegWrite, regw & ex);
        check("memwrite", MemWrite, memw & ex);
        check("pcwrite", PCWrite, pcs & ex);
        @(posedge clk); #1;
        if (ex && flagw[1]) exp_flags[3:2] = alu[3:2];
        if (ex && flagw[0]) exp_flags[1:0] = alu[1:0];
        RegW = 1'b0; MemW = 1'b0; PCS = 1'b0; FlagW = 2'b00;
        check("flags", Flags, exp_flags);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00;
        PCS = 1'b0; NextPC = 1'b0; RegW = 1'b1; MemW = 1'b1; IRWrite = 1'b0;
        exp_flags = 4'h0; exp_exec = 0; exp_skip = 0;

        // Check the reset state. While reset is held, PCWrite follows NextPC.
        #12;
        check("rst_flags", Flags, 4'h0);
        check("rst_condex", CondEx, 1'b0);
        check("rst_regwrite", RegWrite, 1'b0);
        check("rst_memwrite", MemWrite, 1'b0);
        check("rst_pcwrite0", PCWrite, 1'b0);
        NextPC = 1'b1; #1;
        check("rst_pcwrite1", PCWrite, 1'b1);
        NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0;
        check_counters("rst");
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // AL with a full flag write: the flags become 0110 and RegWrite follows RegW.
        run_instr(4'hE, 1'b1, 1'b0, 1'b0, 2'b11, 4'b0110, 2'b00);
        check("al_flags_0110", Flags, 4'b0110);

        // Write only the N,Z half: prior 0100 with ALU 1011 gives 1000.
        run_instr(4'hE, 1'b0, 1'b0, 1'b0, 2'b11, 4'b0100, 2'b00);
        run_instr(4'hE, 1'b0, 1'b0, 1'b0, 2'b10, 4'b1011, 2'b00);
        check("half_nz_1000", Flags, 4'b1000);

        // NE with Z=1 is squashed: no writes of any kind, and the flags stay 0100.
        run_instr(4'hE, 1'b0, 1'b0, 1'b0, 2'b11, 4'b0100, 2'b00);
        run_instr(4'h1, 1'b1, 1'b1, 1'b1, 2'b11, 4'b1111, 2'b00);
        check("ne_squash_flags", Flags, 4'b0100);
        check("ne_squash_condex", CondEx, 1'b0);

        // CondEx=0 with PCS=1 and NextPC=1 gives PCWrite=1. With PCS alone, PCWrite=0.
        PCS = 1'b1; #1;
        check("pcs_noexec_pcwrite", PCWrite, 1'b0);
        NextPC = 1'b1; #1;
        check("nextpc_over_pcs", PCWrite, 1'b1);
        PCS = 1'b0; NextPC = 1'b0;

        // FlagW raised during fetch (while CondEx is still 1 from the AL) must not write.
        run_instr(4'hE, 1'b0, 1'b0, 1'b0, 2'b11, 4'b0010, 2'b00);
        check("pre_fetchflag", Flags, 4'b0010);
        run_instr(4'hE, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1111, 2'b11);
        check("fetch_flagw_ignored", Flags, 4'b0010);

        // Sweep all 16 condition codes against all 16 flag values.
        check_counters("pre_sweep");
        for (int f = 0; f < 16; f++) begin
            run_instr(4'hE, 1'b0, 1'b0, 1'b0, 2'b11, 4'(f), 2'b00);
            for (int c = 0; c < 16; c++)
                run_instr(4'(c), 1'b1, 1'b1, 1'b1, 2'b00, 4'h0, 2'b00);
        end
        check_counters("post_sweep");

        // Assert reset in the middle of execute, with the flags at 1111.
        run_instr(4'hE, 1'b0, 1'b0, 1'b0, 2'b11, 4'b1111, 2'b00);
        check("pre_reset_flags", Flags, 4'b1111);
        Cond = 4'hE; IRWrite = 1'b1; NextPC = 1'b1;
        @(posedge clk); #1;
        IRWrite = 1'b0; NextPC = 1'b0;
        @(posedge clk); #1;
        RegW = 1'b1;
        @(negedge clk);
        check("pre_reset_regwrite", RegWrite, 1'b1);
        #2 reset = 1'b0; #1;
        exp_flags = 4'h0; exp_exec = 0; exp_skip = 0;
        check("midrst_flags", Flags, 4'h0);
        check("midrst_condex", CondEx, 1'b0);
        check("midrst_regwrite", RegWrite, 1'b0);
        check("midrst_pcwrite0", PCWrite, 1'b0);
        NextPC = 1'b1; #1;
        check("midrst_pcwrite1", PCWrite, 1'b1);
        NextPC = 1'b0; RegW = 1'b0;
        check_counters("midrst");
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // After 16 executed instructions the 4-bit counter wraps to 0.
        for (int i = 0; i < 16; i++)
            run_instr(4'hE, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 2'b00);
        check_counters("wrap16");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
